seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter W, default 8, meaning datapath width in bits (legal range 4..32).
REQ-002 SHALL have parameter SAW, default $clog2(W)+1, meaning shift-amount field width.
REQ-003 SHALL have port CLK, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port IN_VALID, input, 1, meaning the operand/opcode bundle is valid.
REQ-006 SHALL have port IN_READY, output, 1, meaning the block accepts the bundle this cycle.
REQ-007 SHALL have port OP, input, 4, meaning opcode: 0 MOV, 1 MOVR, 2 ADD, 3 ADDC, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 SHL, 9 SHR, 10 CMP; 11-15 NOP.
REQ-008 SHALL have ports INPUTA and INPUTB, input, W each, meaning operands; for SHL/SHR, INPUTB[SAW-1:0] is the shift amount.
REQ-009 SHALL have port SC_IN, input, 1, meaning carry-in for ADDC and the fill bit for shifts.
REQ-010 SHALL have port OUT_VALID, output, 1, meaning OUT/SC_OUT/ZERO hold a completed result.
REQ-011 SHALL have port OUT_READY, input, 1, meaning the consumer takes the result this cycle.
REQ-012 SHALL have ports OUT (output, W, result), SC_OUT (output, 1, carry/shift-out), and ZERO (output, 1, result == 0), all registered.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT, and HOLD.
REQ-014 SHALL drive IN_READY = (state==IDLE) or (state==HOLD and OUT_READY); a transfer occurs when IN_VALID and IN_READY are both high.
REQ-015 SHALL, for a non-shift op on transfer, register the result and go to HOLD with OUT_VALID=1 on the next cycle (latency 1).
REQ-016 SHALL compute MOV OUT=A; MOVR OUT=B; AND/OR/XOR bitwise with SC_OUT=0.
REQ-017 SHALL compute ADD {SC_OUT,OUT}=A+B; ADDC {SC_OUT,OUT}=A+B+SC_IN; both are W+1-bit sums with no wrap of the carry.
REQ-018 SHALL compute SUB OUT=A+~B+1 with SC_OUT = no-borrow (1 when A>=B unsigned).
REQ-019 SHALL make CMP produce SUB's flags with OUT=A unchanged.
REQ-020 SHALL make NOP produce OUT=0, SC_OUT=0, ZERO=1, with latency 1.
REQ-021 SHALL clamp the shift amount N to W when N exceeds W.
REQ-022 SHALL treat N=0 as latency 1 with OUT=A and SC_OUT=0.
REQ-023 SHALL, for SHL with N>=1, shift left by N with vacated bits filled with SC_IN, and SC_OUT = the last bit shifted out (A[W-N]).
REQ-024 SHALL, for SHR with N>=1, shift right by N with SC_IN fill, and SC_OUT = A[N-1].
REQ-025 SHALL, in the iterative shifter, enter SHIFT, shift one bit per cycle, and raise OUT_VALID N cycles after transfer (latency N); IN_READY=0 throughout SHIFT.
REQ-026 SHALL hold OUT, SC_OUT, ZERO, and OUT_VALID stable in HOLD until OUT_READY=1.
REQ-027 SHALL, on HOLD with OUT_READY=1 and no new transfer, go to IDLE and drop OUT_VALID next cycle.
REQ-028 SHALL, on HOLD with OUT_READY=1 and a simultaneous new transfer, retire the old result and process the new op in the same cycle (back-to-back, no bubble).
REQ-029 SHALL compute ZERO from the registered OUT, except for CMP, where ZERO = (A==B).
REQ-030 SHALL ignore IN_VALID while in SHIFT, with inputs sampled only on transfer.

Reset
REQ-031 SHALL, on RESET asserted at any time (including mid-SHIFT or HOLD), immediately set state=IDLE, OUT=0, SC_OUT=0, ZERO=1, OUT_VALID=0, IN_READY=0, and clear the shift counter.
REQ-032 SHALL keep IN_READY=0 while RESET is high and assert it in the first cycle after deassertion.
REQ-033 SHALL discard any in-flight operation on reset, producing no OUT_VALID for it.

Configuration
REQ-034 SHALL, with macro SEQ_ALU_BARREL_EN defined, compute SHL/SHR in a combinational barrel shifter with latency 1 for all N, never enter SHIFT, and produce results identical to the iterative mode.
REQ-035 SHALL, without SEQ_ALU_BARREL_EN, use the iterative shifter of REQ-025.

Verification
REQ-036 SHALL cover: W=8, ADD A=0xF0 B=0x20 -> next cycle OUT=0x10, SC_OUT=1, ZERO=0, OUT_VALID=1.
REQ-037 SHALL cover: SHL A=0xB3 N=1 SC_IN=1 -> OUT=0x67, SC_OUT=1; iterative latency 1.
REQ-038 SHALL cover: SHR A=0x96 N=3 SC_IN=0 -> OUT=0x12, SC_OUT=1; OUT_VALID 3 cycles after transfer (iterative) or 1 cycle (barrel); IN_READY low during SHIFT.
REQ-039 SHALL cover: SUB A=0x05 B=0x05 then CMP A=0x03 B=0x07 with OUT_READY tied high -> back-to-back results OUT=0x00/ZERO=1/SC_OUT=1, then OUT=0x03/ZERO=0/SC_OUT=0, with no idle cycle between.
REQ-040 SHALL cover: OUT_READY held low 4 cycles after XOR A=0xAA B=0xFF -> OUT=0x55 stable and IN_READY=0 for all 4 cycles.
REQ-041 SHALL cover: RESET pulsed during cycle 2 of SHL N=5 -> outputs reset immediately, no OUT_VALID for that op, and a subsequent MOV A=0x3C returns 0x3C.

Source files
------------

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with valid/ready handshake and iterative shifter
// Define SEQ_ALU_BARREL_EN to replace the iterative shifter with a single-cycle barrel shifter.
module seq_alu #(
   parameter int W   = 8,
   parameter int SAW = $clog2(W) + 1
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         IN_VALID,
   output logic         IN_READY,
   input  logic [3:0]   OP,
   input  logic [W-1:0] INPUTA,
   input  logic [W-1:0] INPUTB,
   input  logic         SC_IN,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic [W-1:0] OUT,
   output logic         SC_OUT,
   output logic         ZERO
);

   localparam logic [3:0] OP_MOV  = 4'd0;
   localparam logic [3:0] OP_MOVR = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_ADDC = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_SHL  = 4'd8;
   localparam logic [3:0] OP_SHR  = 4'd9;
   localparam logic [3:0] OP_CMP  = 4'd10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic           xfer;

   logic [W-1:0]   out_r;
   logic           sc_r;
   logic           zero_r;
   logic [SAW-1:0] cnt_r;
   logic           left_r;
   logic           fill_r;

   logic [SAW-1:0] shamt_raw;
   logic [SAW-1:0] shamt;

   logic [W-1:0]   alu_out;
   logic           alu_sc;
   logic           alu_zero;
   logic [SAW-1:0] alu_cnt;
   logic           alu_iter;
   logic [W:0]     sum;
   logic [W:0]     first_step;
   logic [W:0]     iter_step;

   // Single-bit shift step; returns {bit shifted out, shifted value}.
   function automatic logic [W:0] step1(input logic [W-1:0] v, input logic left, input logic fill);
      if (left)
         step1 = {v[W-1], v[W-2:0], fill};
      else
         step1 = {v[0], fill, v[W-1:1]};
   endfunction

   assign xfer      = IN_VALID && IN_READY;
   assign shamt_raw = INPUTB[SAW-1:0];
   assign shamt     = (shamt_raw > SAW'(W)) ? SAW'(W) : shamt_raw;

   assign first_step = step1(INPUTA, OP == OP_SHL, SC_IN);
   assign iter_step  = step1(out_r, left_r, fill_r);

`ifdef SEQ_ALU_BARREL_EN
   logic [W-1:0] bar_out;
   logic         bar_sc;

   // Unrolled chain of single-bit steps so results match the iterative mode exactly.
   always_comb begin
      bar_out = INPUTA;
      bar_sc  = 1'b0;
      for (int k = 0; k < W; k++) begin
         if (k < int'(shamt)) begin
            if (OP == OP_SHL) begin
               bar_sc  = bar_out[W-1];
               bar_out = {bar_out[W-2:0], SC_IN};
            end else begin
               bar_sc  = bar_out[0];
               bar_out = {SC_IN, bar_out[W-1:1]};
            end
         end
      end
   end
`endif

   always_comb begin
      alu_out  = '0;
      alu_sc   = 1'b0;
      alu_cnt  = '0;
      alu_iter = 1'b0;
      sum      = '0;
      case (OP)
         OP_MOV:  alu_out = INPUTA;
         OP_MOVR: alu_out = INPUTB;
         OP_ADD: begin
            sum               = {1'b0, INPUTA} + {1'b0, INPUTB};
            {alu_sc, alu_out} = sum;
         end
         OP_ADDC: begin
            sum               = {1'b0, INPUTA} + {1'b0, INPUTB} + {{W{1'b0}}, SC_IN};
            {alu_sc, alu_out} = sum;
         end
         OP_SUB: begin
            sum               = {1'b0, INPUTA} + {1'b0, ~INPUTB} + {{W{1'b0}}, 1'b1};
            {alu_sc, alu_out} = sum;
         end
         OP_CMP: begin
            sum     = {1'b0, INPUTA} + {1'b0, ~INPUTB} + {{W{1'b0}}, 1'b1};
            alu_sc  = sum[W];
            alu_out = INPUTA;
         end
         OP_AND:  alu_out = INPUTA & INPUTB;
         OP_OR:   alu_out = INPUTA | INPUTB;
         OP_XOR:  alu_out = INPUTA ^ INPUTB;
         OP_SHL, OP_SHR: begin
`ifdef SEQ_ALU_BARREL_EN
            alu_out = bar_out;
            alu_sc  = bar_sc;
`else
            // The first shift happens on the transfer edge, the rest in SHIFT.
            if (shamt == '0) begin
               alu_out = INPUTA;
            end else begin
               {alu_sc, alu_out} = first_step;
               alu_cnt           = shamt - SAW'(1);
               alu_iter          = (shamt > SAW'(1));
            end
`endif
         end
         default: begin
            alu_out = '0;
            alu_sc  = 1'b0;
         end
      endcase
      alu_zero = (OP == OP_CMP) ? (INPUTA == INPUTB) : (alu_out == '0);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (xfer)
               state_nxt = alu_iter ? SHIFT : HOLD;
         end
         SHIFT: begin
            if (cnt_r <= SAW'(1))
               state_nxt = HOLD;
         end
         HOLD: begin
            if (OUT_READY) begin
               if (xfer)
                  state_nxt = alu_iter ? SHIFT : HOLD;
               else
                  state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      IN_READY  = !RESET && ((state == IDLE) || ((state == HOLD) && OUT_READY));
      OUT_VALID = (state == HOLD);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         out_r  <= '0;
         sc_r   <= 1'b0;
         zero_r <= 1'b1;
         cnt_r  <= '0;
         left_r <= 1'b0;
         fill_r <= 1'b0;
      end else if (xfer) begin
         out_r  <= alu_out;
         sc_r   <= alu_sc;
         zero_r <= alu_zero;
         cnt_r  <= alu_cnt;
         left_r <= (OP == OP_SHL);
         fill_r <= SC_IN;
      end else if (state == SHIFT) begin
         out_r  <= iter_step[W-1:0];
         sc_r   <= iter_step[W];
         zero_r <= (iter_step[W-1:0] == '0);
         cnt_r  <= cnt_r - SAW'(1);
      end
   end

   assign OUT    = out_r;
   assign SC_OUT = sc_r;
   assign ZERO   = zero_r;

endmodule
